// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: hazard FSM states, writeback/regfile/memory
// control codes and operand forward-select values.
package pipe_pkg;

    localparam logic [2:0] ST_RUN      = 3'd0;
    localparam logic [2:0] ST_LD_STALL = 3'd1;
    localparam logic [2:0] ST_MEM_WAIT = 3'd2;
    localparam logic [2:0] ST_DRAIN    = 3'd3;
    localparam logic [2:0] ST_HALTED   = 3'd4;

    localparam logic [1:0] WBSel_ALU  = 2'b00;
    localparam logic [1:0] WBSel_PC   = 2'b01;
    localparam logic [1:0] WBSel_LOAD = 2'b10;

    localparam logic RWrEn_WRITE = 1'b0;
    localparam logic RWrEn_NONE  = 1'b1;

    localparam logic [1:0] MemRW_NONE  = 2'b00;
    localparam logic [1:0] MemRW_READ  = 2'b01;
    localparam logic [1:0] MemRW_WRITE = 2'b10;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Longest run of RAW stall cycles when operands are not forwarded.
    localparam logic [1:0] RAW_STALL_MAX = 2'd3;

    function automatic logic is_load(input logic [1:0] wbsel);
        return wbsel == WBSel_LOAD;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Flags when one pipeline stage's pending register write targets a source
// register read by the instruction currently in ID.
module hazard_cmp
    import pipe_pkg::*;
(
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       use_rs1_i,
    input  logic       use_rs2_i,
    input  logic [4:0] rd_i,
    input  logic       rwren_n_i,
    input  logic       valid_i,
    output logic       hit_rs1_o,
    output logic       hit_rs2_o
);

    logic writes_reg;

    // x0 is hard-wired, so a write to it never produces a dependency.
    assign writes_reg = valid_i && (rwren_n_i == RWrEn_WRITE) && (rd_i != 5'd0);
    assign hit_rs1_o  = writes_reg && use_rs1_i && (rs1_i == rd_i);
    assign hit_rs2_o  = writes_reg && use_rs2_i && (rs2_i == rd_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core (falling-edge clocked).
// Define HAZARD_FORWARD_EN to enable operand forwarding (load-use stalls only).
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [4:0]             Rsrc1_id,
    input  logic [4:0]             Rsrc2_id,
    input  logic                   use_rs1_id,
    input  logic                   use_rs2_id,
    input  logic                   valid_id,
    input  logic                   halt_id,
    input  logic [4:0]             RegDst_ex,
    input  logic                   RWrEn_ex,
    input  logic [1:0]             WBSel_ex,
    input  logic                   valid_ex,
    input  logic [4:0]             Rdst_mem,
    input  logic                   RWrEn_mem,
    input  logic                   valid_mem,
    input  logic [4:0]             Rdst_wb,
    input  logic                   RWrEn_wb,
    input  logic                   valid_wb,
    input  logic                   halt_wb,
    input  logic                   redirect_ex,
    input  logic                   mem_busy,
    output logic                   pc_hold,
    output logic                   stall_ifid,
    output logic                   stall_idex,
    output logic                   squash_ifid,
    output logic                   squash_idex,
    output logic                   wen_n_exmem,
    output logic                   wen_n_memwb,
    output logic [1:0]             fwdA_sel,
    output logic [1:0]             fwdB_sel,
    output logic                   halted,
    output logic [2:0]             state,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    logic [2:0]             state_q, state_d;
    logic [2:0]             ret_q, ret_d;
    logic [2:0]             eff_state;
    logic [1:0]             raw_cnt_q, raw_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic                   load_use, hazard_stall;
    logic [1:0]             fwdA_raw, fwdB_raw;
    logic                   count_en;

    hazard_cmp u_cmp_ex (
        .rs1_i(Rsrc1_id), .rs2_i(Rsrc2_id), .use_rs1_i(use_rs1_id), .use_rs2_i(use_rs2_id),
        .rd_i(RegDst_ex), .rwren_n_i(RWrEn_ex), .valid_i(valid_ex),
        .hit_rs1_o(ex_hit1), .hit_rs2_o(ex_hit2)
    );

    hazard_cmp u_cmp_mem (
        .rs1_i(Rsrc1_id), .rs2_i(Rsrc2_id), .use_rs1_i(use_rs1_id), .use_rs2_i(use_rs2_id),
        .rd_i(Rdst_mem), .rwren_n_i(RWrEn_mem), .valid_i(valid_mem),
        .hit_rs1_o(mem_hit1), .hit_rs2_o(mem_hit2)
    );

    hazard_cmp u_cmp_wb (
        .rs1_i(Rsrc1_id), .rs2_i(Rsrc2_id), .use_rs1_i(use_rs1_id), .use_rs2_i(use_rs2_id),
        .rd_i(Rdst_wb), .rwren_n_i(RWrEn_wb), .valid_i(valid_wb),
        .hit_rs1_o(wb_hit1), .hit_rs2_o(wb_hit2)
    );

    assign load_use = is_load(WBSel_ex) && (ex_hit1 || ex_hit2);

`ifdef HAZARD_FORWARD_EN
    assign hazard_stall = load_use;

    // Selects travel with the ID instruction into ID/EX: today's EX producer
    // sits in EX/MEM and today's MEM producer in MEM/WB when it executes.
    always_comb begin
        fwdA_raw = FWD_REG;
        fwdB_raw = FWD_REG;
        if (ex_hit1)
            fwdA_raw = FWD_EXMEM;
        else if (mem_hit1)
            fwdA_raw = FWD_MEMWB;
        if (ex_hit2)
            fwdB_raw = FWD_EXMEM;
        else if (mem_hit2)
            fwdB_raw = FWD_MEMWB;
    end
`else
    // A load in EX must never be released by the RAW stall cap.
    assign hazard_stall = load_use ||
        ((ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2 || wb_hit1 || wb_hit2) &&
         (raw_cnt_q != RAW_STALL_MAX));
    assign fwdA_raw = FWD_REG;
    assign fwdB_raw = FWD_REG;
`endif

    assign fwdA_sel  = RST ? fwdA_raw : FWD_REG;
    assign fwdB_sel  = RST ? fwdB_raw : FWD_REG;
    assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        raw_cnt_d   = raw_cnt_q;
        pc_hold     = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        squash_ifid = 1'b0;
        squash_idex = 1'b0;
        wen_n_exmem = 1'b0;
        wen_n_memwb = 1'b0;
        if (!RST) begin
            state_d   = ST_RUN;
            ret_d     = ST_RUN;
            raw_cnt_d = 2'd0;
        end else if (state_q == ST_HALTED) begin
            pc_hold     = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            wen_n_exmem = 1'b1;
            wen_n_memwb = 1'b1;
        end else if (mem_busy) begin
            pc_hold     = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            wen_n_exmem = 1'b1;
            wen_n_memwb = 1'b1;
            state_d     = ST_MEM_WAIT;
            ret_d       = eff_state;
        end else if (eff_state == ST_DRAIN) begin
            pc_hold     = 1'b1;
            squash_ifid = 1'b1;
            state_d     = halt_wb ? ST_HALTED : ST_DRAIN;
        end else if (redirect_ex) begin
            squash_ifid = 1'b1;
            squash_idex = 1'b1;
            state_d     = ST_RUN;
            raw_cnt_d   = 2'd0;
        end else if (hazard_stall) begin
            pc_hold     = 1'b1;
            stall_ifid  = 1'b1;
            squash_idex = 1'b1;
            state_d     = ST_LD_STALL;
            raw_cnt_d   = raw_cnt_q + 2'd1;
        end else if (halt_id && valid_id) begin
            state_d   = ST_DRAIN;
            raw_cnt_d = 2'd0;
        end else begin
            state_d   = ST_RUN;
            raw_cnt_d = 2'd0;
        end
    end

    assign count_en = pc_hold && ((state_q == ST_RUN) || (state_q == ST_LD_STALL) ||
                                  (state_q == ST_MEM_WAIT));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (count_en && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_RUN;
            ret_q       <= ST_RUN;
            raw_cnt_q   <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            raw_cnt_q   <= raw_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign state        = state_q;
    assign halted       = (state_q == ST_HALTED);
    assign stall_cycles = stall_cnt_q;

endmodule
